// File: rtl/bus_steal_sched.sv
// C64 bus-steal scheduler: BA warning, per-half AEC, sequencer cross-check.
// Optional external idle-slot grant enabled by `EXT_IDLE_SLOT_EN.
module bus_steal_sched (
  input  logic       clk_dot4x,
  input  logic       rst,
  input  logic       clk_phi,
  input  logic       phi_phase_start_1,
  input  logic [1:0] chip,
  input  logic [6:0] cycle_num,
  input  logic       badline,
  input  logic [7:0] sprite_dma,
  input  logic [3:0] cycle_type,
  input  logic       ext_req,
  output logic       ba,
  output logic       aec,
  output logic       mismatch,
  output logic       ext_gnt
);

  localparam logic [1:0] CHIP6567R8   = 2'd0;
  localparam logic [1:0] CHIP6569     = 2'd1;
  localparam logic [1:0] CHIP6567R56A = 2'd2;

  localparam logic [3:0] VIC_HS1 = 4'd5;
  localparam logic [3:0] VIC_HS3 = 4'd8;
  localparam logic [3:0] VIC_HRC = 4'd9;
  localparam logic [3:0] VIC_HGC = 4'd10;

  logic [6:0] w_len;
  logic [6:0] w_s0;
  logic [6:0] w_tgt0 [8];
  logic [6:0] w_tgt1 [8];
  logic [7:0] w_dist;
  logic       w_ba_hit;
  logic       w_stolen;
  logic       w_hi_steal;

  logic       r_chk;
  logic       r_seen;
  logic [6:0] r_last;

  // line length and first sprite cycle for the selected chip
  always_comb begin
    w_len = 7'd63;
    w_s0  = 7'd57;
    case (chip)
      CHIP6569: begin
        w_len = 7'd63;
        w_s0  = 7'd57;
      end
      CHIP6567R56A: begin
        w_len = 7'd64;
        w_s0  = 7'd58;
      end
      CHIP6567R8: begin
        w_len = 7'd65;
        w_s0  = 7'd58;
      end
      default: begin
        w_len = 7'd63;
        w_s0  = 7'd57;
      end
    endcase
  end

  // sprite s-access cycles, folded back into 0..N-1
  always_comb begin
    for (int s = 0; s < 8; s++) begin
      if (w_s0 + 7'(2 * s) >= w_len)
        w_tgt0[s] = w_s0 + 7'(2 * s) - w_len;
      else
        w_tgt0[s] = w_s0 + 7'(2 * s);
      if (w_s0 + 7'(2 * s + 1) >= w_len)
        w_tgt1[s] = w_s0 + 7'(2 * s + 1) - w_len;
      else
        w_tgt1[s] = w_s0 + 7'(2 * s + 1);
    end
  end

  // steal of this cycle, and any steal within the 4-cycle BA window
  always_comb begin
    w_stolen = badline && cycle_num >= 7'd14
            && cycle_num <= 7'd53;
    w_ba_hit = badline && cycle_num >= 7'd11
            && cycle_num <= 7'd53;
    w_dist   = 8'd0;
    for (int s = 0; s < 8; s++) begin
      w_dist = {1'b0, w_tgt0[s]} - {1'b0, cycle_num};
      if (w_dist[7])
        w_dist = w_dist + {1'b0, w_len};
      if (sprite_dma[s] && w_dist <= 8'd3)
        w_ba_hit = 1'b1;
      w_dist = {1'b0, w_tgt1[s]} - {1'b0, cycle_num};
      if (w_dist[7])
        w_dist = w_dist + {1'b0, w_len};
      if (sprite_dma[s] && w_dist <= 8'd3)
        w_ba_hit = 1'b1;
      if (sprite_dma[s] && (w_tgt0[s] == cycle_num
          || w_tgt1[s] == cycle_num))
        w_stolen = 1'b1;
    end
  end

  // sequencer's view of a stolen phi-high half
  always_comb begin
    w_hi_steal = (cycle_type == VIC_HS1)
              || (cycle_type == VIC_HS3)
              || (cycle_type == VIC_HRC)
              || (cycle_type == VIC_HGC);
  end

  // BA at phi-low strobe, AEC at every strobe
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      ba    <= 1'b1;
      aec   <= 1'b1;
      r_chk <= 1'b0;
    end else begin
      r_chk <= 1'b0;
      if (phi_phase_start_1) begin
        if (!clk_phi) begin
          ba  <= !w_ba_hit;
          aec <= 1'b0;
        end else begin
          aec   <= !w_stolen;
          r_chk <= 1'b1;
        end
      end
    end
  end

  // arm the cross-check once cycle_num has wrapped to 0
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      r_seen <= 1'b0;
      r_last <= 7'd0;
    end else if (phi_phase_start_1 && !clk_phi) begin
      r_last <= cycle_num;
      if (cycle_num == 7'd0 && r_last != 7'd0)
        r_seen <= 1'b1;
    end
  end

  // sticky disagreement between our AEC and the sequencer
  always_ff @(posedge clk_dot4x) begin
    if (rst)
      mismatch <= 1'b0;
    else if (r_chk && r_seen && (!aec != w_hi_steal))
      mismatch <= 1'b1;
  end

`ifdef EXT_IDLE_SLOT_EN
  localparam logic [3:0] VIC_LPI2 = 4'd1;
  localparam logic [3:0] VIC_LI   = 4'd13;

  logic r_gpend;

  // grant idle phi-low slots for the rest of the half
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      r_gpend <= 1'b0;
      ext_gnt <= 1'b0;
    end else begin
      r_gpend <= phi_phase_start_1 && !clk_phi;
      if (phi_phase_start_1)
        ext_gnt <= 1'b0;
      else if (r_gpend && ext_req
               && (cycle_type == VIC_LI
                   || cycle_type == VIC_LPI2))
        ext_gnt <= 1'b1;
    end
  end
`else
  logic w_unused_req;
  assign w_unused_req = ext_req;

  // no external slot in this build
  always_ff @(posedge clk_dot4x) begin
    ext_gnt <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_bus_steal_sched.sv
// Bench for bus_steal_sched: line-level steal model plus
// literal per-cycle expectations for each scenario.
module tb_bus_steal_sched;

  localparam logic [1:0] C_R8   = 2'd0;
  localparam logic [1:0] C_6569 = 2'd1;
  localparam logic [1:0] C_R56A = 2'd2;

  localparam logic [3:0] T_LPI2 = 4'd1;
  localparam logic [3:0] T_LG   = 4'd4;
  localparam logic [3:0] T_HS1  = 4'd5;
  localparam logic [3:0] T_HS3  = 4'd8;
  localparam logic [3:0] T_HRC  = 4'd9;
  localparam logic [3:0] T_HGC  = 4'd10;
  localparam logic [3:0] T_HI   = 4'd12;
  localparam logic [3:0] T_LI   = 4'd13;

  logic       clk_dot4x = 1'b0;
  logic       rst = 1'b1;
  logic       clk_phi = 1'b0;
  logic       phi_phase_start_1 = 1'b0;
  logic [1:0] chip = C_6569;
  logic [6:0] cycle_num = 7'd0;
  logic       badline = 1'b0;
  logic [7:0] sprite_dma = 8'h00;
  logic [3:0] cycle_type = T_HI;
  logic       ext_req = 1'b0;
  logic       ba, aec, mismatch, ext_gnt;

  int total = 0;
  int bad = 0;

  logic chk_en = 1'b0;
  logic exp_ba, exp_aec, exp_mm, exp_gnt;
  logic seen;
  int   prev_n;
  logic ba_log  [0:64];
  logic aec_log [0:64];
  logic gnt_log [0:64];

  bus_steal_sched dut (
    .clk_dot4x         (clk_dot4x),
    .rst               (rst),
    .clk_phi           (clk_phi),
    .phi_phase_start_1 (phi_phase_start_1),
    .chip              (chip),
    .cycle_num         (cycle_num),
    .badline           (badline),
    .sprite_dma        (sprite_dma),
    .cycle_type        (cycle_type),
    .ext_req           (ext_req),
    .ba                (ba),
    .aec               (aec),
    .mismatch          (mismatch),
    .ext_gnt           (ext_gnt)
  );

  always #5 clk_dot4x = ~clk_dot4x;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic act,
                     input logic want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t",
               nm, act, want, $time);
    end
  endtask

  always @(negedge clk_dot4x) begin
    if (chk_en) begin
      chk("ba", ba, exp_ba);
      chk("aec", aec, exp_aec);
      chk("mismatch", mismatch, exp_mm);
      chk("ext_gnt", ext_gnt, exp_gnt);
    end
  end

  function automatic int line_len();
    case (chip)
      C_R56A:  return 64;
      C_R8:    return 65;
      default: return 63;
    endcase
  endfunction

  function automatic int first_spr();
    return (chip == C_6569) ? 57 : 58;
  endfunction

  function automatic bit spr_a(int s, int n);
    return ((first_spr() + 2 * s) % line_len()) == n;
  endfunction

  function automatic bit spr_b(int s, int n);
    return ((first_spr() + 2 * s + 1) % line_len()) == n;
  endfunction

  function automatic bit stolen_m(int n);
    if (badline && n >= 14 && n <= 53) return 1'b1;
    for (int s = 0; s < 8; s++)
      if (sprite_dma[s] && (spr_a(s, n) || spr_b(s, n)))
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic ba_m(int n);
    for (int k = 0; k < 4; k++)
      if (stolen_m((n + k) % line_len())) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] low_type(int n);
    if (chip == C_6569 && (n == 55 || n == 56)) return T_LI;
    for (int s = 0; s < 8; s++)
      if (!sprite_dma[s] && spr_b(s, n)) return T_LPI2;
    return T_LG;
  endfunction

  function automatic logic [3:0] high_type(int n);
    if (badline && n >= 14 && n <= 53) return T_HGC;
    for (int s = 0; s < 8; s++) begin
      if (sprite_dma[s] && spr_a(s, n)) return T_HS1;
      if (sprite_dma[s] && spr_b(s, n)) return T_HS3;
    end
    return T_HI;
  endfunction

  function automatic bit hi_set(logic [3:0] t);
    return t == T_HS1 || t == T_HS3 || t == T_HRC || t == T_HGC;
  endfunction

  task automatic run_cycle(input int n, input bit force_hgc,
                           input bit drop_req);
    #1;
    cycle_num = 7'(n);
    clk_phi = 1'b0;
    phi_phase_start_1 = 1'b1;
    if (n == 0 && prev_n != 0) seen = 1'b1;
    prev_n = n;
    @(posedge clk_dot4x); #1;
    phi_phase_start_1 = 1'b0;
    cycle_type = low_type(n);
    exp_ba = ba_m(n);
    exp_aec = 1'b0;
    exp_gnt = 1'b0;
    @(posedge clk_dot4x); #1;
`ifdef EXT_IDLE_SLOT_EN
    exp_gnt = ext_req && (cycle_type == T_LI
                       || cycle_type == T_LPI2);
`endif
    if (drop_req) ext_req = 1'b0;
    @(posedge clk_dot4x); #1;
    ba_log[n] = ba;
    gnt_log[n] = ext_gnt;
    @(posedge clk_dot4x); #1;
    clk_phi = 1'b1;
    phi_phase_start_1 = 1'b1;
    @(posedge clk_dot4x); #1;
    phi_phase_start_1 = 1'b0;
    cycle_type = force_hgc ? T_HGC : high_type(n);
    exp_aec = !stolen_m(n);
    exp_gnt = 1'b0;
    @(posedge clk_dot4x); #1;
    if (seen && ((!exp_aec) != hi_set(cycle_type)))
      exp_mm = 1'b1;
    @(posedge clk_dot4x); #1;
    aec_log[n] = aec;
    @(posedge clk_dot4x);
  endtask

  task automatic run_span(input int a, input int b);
    for (int n = a; n <= b; n++) run_cycle(n, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    @(posedge clk_dot4x); #1;
    rst = 1'b1;
    phi_phase_start_1 = 1'b0;
    @(posedge clk_dot4x);
    @(posedge clk_dot4x); #1;
    rst = 1'b0;
    exp_ba = 1'b1;
    exp_aec = 1'b1;
    exp_mm = 1'b0;
    exp_gnt = 1'b0;
    seen = 1'b0;
    prev_n = 0;
    chk_en = 1'b1;
    chk("rst_ba", ba, 1'b1);
    chk("rst_aec", aec, 1'b1);
    chk("rst_mm", mismatch, 1'b0);
    chk("rst_gnt", ext_gnt, 1'b0);
    @(posedge clk_dot4x);
  endtask

  initial begin
    do_reset();

    chip = C_6569; sprite_dma = 8'h01; badline = 1'b0;
    run_span(0, 62);
    for (int n = 0; n < 63; n++) begin
      chk("t1_ba", ba_log[n], !(n >= 54 && n <= 58));
      chk("t1_aec", aec_log[n], !(n == 57 || n == 58));
    end
    chk("t1_mm", mismatch, 1'b0);

    sprite_dma = 8'h08;
    run_span(0, 62);
    for (int n = 0; n < 63; n++) begin
      chk("t2_ba", ba_log[n],
          !(n == 60 || n == 61 || n == 62 || n == 0 || n == 1));
      chk("t2_aec", aec_log[n], !(n == 0 || n == 1));
    end

    do_reset();
    chip = C_R8; sprite_dma = 8'h00; badline = 1'b1;
    run_span(0, 64);
    for (int n = 0; n < 65; n++) begin
      chk("t3_ba", ba_log[n], !(n >= 11 && n <= 53));
      chk("t3_aec", aec_log[n], !(n >= 14 && n <= 53));
    end
    chk("t3_ba54", ba_log[54], 1'b1);

    chip = C_6569; badline = 1'b0;
    run_span(0, 29);
    badline = 1'b1;
    run_span(30, 62);
    badline = 1'b0;
    chk("t4_ba29", ba_log[29], 1'b1);
    chk("t4_ba30", ba_log[30], 1'b0);
    chk("t4_aec30", aec_log[30], 1'b0);

    do_reset();
    chip = C_R56A; sprite_dma = 8'h00; badline = 1'b0;
    run_span(0, 19);
    run_cycle(20, 1'b1, 1'b0);
    chk("t5_suppressed", mismatch, 1'b0);
    run_span(21, 63);
    run_span(0, 63);
    run_span(0, 19);
    chk("t5_pre", mismatch, 1'b0);
    run_cycle(20, 1'b1, 1'b0);
    chk("t5_set", mismatch, 1'b1);
    run_span(21, 63);
    chk("t5_hold", mismatch, 1'b1);
    do_reset();
    chk("t5_clear", mismatch, 1'b0);

    chip = C_6569; ext_req = 1'b1;
    run_span(0, 62);
    for (int n = 0; n < 63; n++) begin
`ifdef EXT_IDLE_SLOT_EN
      chk("t6_gnt", gnt_log[n],
          n == 55 || n == 56 || n == 58 || n == 60 || n == 62
          || n == 1 || n == 3 || n == 5 || n == 7 || n == 9);
`else
      chk("t6_gnt", gnt_log[n], 1'b0);
`endif
    end
    run_span(0, 55);
    run_cycle(56, 1'b0, 1'b1);
    run_span(57, 62);
`ifdef EXT_IDLE_SLOT_EN
    chk("t6_keep", gnt_log[56], 1'b1);
`else
    chk("t6_keep", gnt_log[56], 1'b0);
`endif
    chk("t6_after", gnt_log[58], 1'b0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
